// File: rtl/ddr_fifo_chk_pkg.sv
// Shared definitions for the DDR FIFO stream checker: FSM encoding,
// error-bit positions and the {tag, counter} pattern helper.
package ddr_fifo_chk_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ARMED = 3'd1,
      ST_FILL  = 3'd2,
      ST_RUN   = 3'd3,
      ST_HALT  = 3'd4
   } chk_state_e;

   localparam int ERR_RD_SEQ = 0;
   localparam int ERR_WR_SEQ = 1;
   localparam int ERR_WR_TAG = 2;
   localparam int ERR_RD_TAG = 3;
   localparam int ERR_RD_GAP = 4;
   localparam int ERR_WR_GAP = 5;
   localparam int ERR_UNF    = 6;
   localparam int ERR_OVF    = 7;

   // Bits attributed to the read side when choosing what to capture.
   localparam logic [7:0] RD_SIDE_MASK = 8'b0101_1001;
   localparam logic [31:0] SAT32 = 32'hFFFF_FFFF;

   // Tag field (above the counter) must replicate the counter's low TAG_W bits.
   function automatic logic tag_ok(input logic [127:0] beat, input int data_w, input int cnt_w);
      logic [127:0] mask;
      mask = (128'd1 << (data_w - cnt_w)) - 128'd1;
      return ~|(((beat >> cnt_w) ^ beat) & mask);
   endfunction

endpackage

// File: rtl/stream_seq_check.sv
// Per-stream pattern checker: tracks the expected counter and flags sequence
// breaks, tag corruption and all-ones counter beats combinationally.
module stream_seq_check
   import ddr_fifo_chk_pkg::*;
#(
   parameter int DATA_W = 48,
   parameter int CNT_W  = 32
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              clear_i,
   input  logic              beat_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              ref_vld_i,
   input  logic [CNT_W-1:0]  ref_cnt_i,
   output logic              seeded_o,
   output logic              seq_err_o,
   output logic              tag_err_o,
   output logic              wrap_o,
   output logic [DATA_W-1:0] exp_beat_o
);
   localparam int TAG_W = DATA_W - CNT_W;

   logic             seeded_q, seeded_d;
   logic [CNT_W-1:0] exp_q, exp_d;
   logic [CNT_W-1:0] cnt, exp_cnt;

   assign cnt = data_i[CNT_W-1:0];
   // Unseeded stream: compare against the reference if one exists, else self-seed.
   assign exp_cnt = seeded_q ? exp_q : (ref_vld_i ? ref_cnt_i : cnt);

   assign seeded_o   = seeded_q;
   assign seq_err_o  = beat_i & (cnt != exp_cnt);
   assign tag_err_o  = beat_i & ~tag_ok(128'(data_i), DATA_W, CNT_W);
   assign wrap_o     = beat_i & (&cnt);
   assign exp_beat_o = {exp_cnt[TAG_W-1:0], exp_cnt};

   always_comb begin
      seeded_d = seeded_q;
      exp_d    = exp_q;
      if (clear_i) begin
         seeded_d = 1'b0;
         exp_d    = '0;
      end else if (beat_i) begin
         seeded_d = 1'b1;
         exp_d    = cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         seeded_q <= 1'b0;
         exp_q    <= '0;
      end else begin
         seeded_q <= seeded_d;
         exp_q    <= exp_d;
      end
   end

endmodule

// File: rtl/ddr_fifo_stream_checker.sv
// Self-checking monitor for DDR FIFO traffic: pattern checks on both data
// streams, occupancy/latency tracking, sticky errors and first-error capture.
module ddr_fifo_stream_checker
   import ddr_fifo_chk_pkg::*;
#(
   parameter int DATA_W      = 48,
   parameter int CNT_W       = 32,
   parameter int DEPTH       = 4096,
   parameter int OCC_W       = 16,
   parameter int STOP_ON_ERR = 0
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic              clr_i,
   input  logic              cont_mode_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic              wr_valid_i,
   input  logic [DATA_W-1:0] rd_data_i,
   input  logic              rd_valid_i,
   output logic [2:0]        state_o,
   output logic [7:0]        error_o,
   output logic [31:0]       err_count_o,
   output logic              first_err_vld_o,
   output logic [DATA_W-1:0] first_err_exp_o,
   output logic [DATA_W-1:0] first_err_act_o,
   output logic [31:0]       wrap_count_o,
   output logic [31:0]       fill_latency_o,
   output logic [OCC_W-1:0]  occupancy_o
);
   localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(DEPTH);

   chk_state_e        state_q, state_d;
   logic [7:0]        error_q, error_d, err_now;
   logic [31:0]       err_cnt_q, err_cnt_d;
   logic              fe_vld_q, fe_vld_d;
   logic [DATA_W-1:0] fe_exp_q, fe_exp_d, fe_act_q, fe_act_d;
   logic [31:0]       wrap_q, wrap_d, fill_q, fill_d;
   logic [OCC_W-1:0]  occ_q, occ_d;
   logic              fw_vld_q, fw_vld_d;
   logic [CNT_W-1:0]  fw_cnt_q, fw_cnt_d;

   logic active, start_acc, stat_clr, wr_beat, rd_beat, any_err;
   logic ref_vld;
   logic [CNT_W-1:0] ref_cnt;
   logic wr_seeded, wr_seq, wr_tag, wr_wrap;
   logic rd_seeded, rd_seq, rd_tag, rd_wrap;
   logic [DATA_W-1:0] wr_exp, rd_exp;

   assign active    = (state_q == ST_ARMED) | (state_q == ST_FILL) | (state_q == ST_RUN);
   assign start_acc = start_i & ((state_q == ST_IDLE) | (state_q == ST_HALT));
   assign stat_clr  = clr_i | start_acc;
   assign wr_beat   = wr_valid_i & active & ~clr_i;
   assign rd_beat   = rd_valid_i & active & ~clr_i;

   // First read beat is held to the counter of the first write beat (even same-cycle).
   assign ref_vld = fw_vld_q | wr_beat;
   assign ref_cnt = fw_vld_q ? fw_cnt_q : wr_data_i[CNT_W-1:0];

   stream_seq_check #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_wr_chk (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .clear_i    (stat_clr),
      .beat_i     (wr_beat),
      .data_i     (wr_data_i),
      .ref_vld_i  (1'b0),
      .ref_cnt_i  ('0),
      .seeded_o   (wr_seeded),
      .seq_err_o  (wr_seq),
      .tag_err_o  (wr_tag),
      .wrap_o     (wr_wrap),
      .exp_beat_o (wr_exp)
   );

   stream_seq_check #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_rd_chk (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .clear_i    (stat_clr),
      .beat_i     (rd_beat),
      .data_i     (rd_data_i),
      .ref_vld_i  (ref_vld),
      .ref_cnt_i  (ref_cnt),
      .seeded_o   (rd_seeded),
      .seq_err_o  (rd_seq),
      .tag_err_o  (rd_tag),
      .wrap_o     (rd_wrap),
      .exp_beat_o (rd_exp)
   );

   always_comb begin
      err_now             = '0;
      err_now[ERR_RD_SEQ] = rd_seq;
      err_now[ERR_WR_SEQ] = wr_seq;
      err_now[ERR_WR_TAG] = wr_tag;
      err_now[ERR_RD_TAG] = rd_tag;
      err_now[ERR_RD_GAP] = cont_mode_i & ~clr_i & (state_q == ST_RUN) & rd_seeded & ~rd_valid_i;
      err_now[ERR_WR_GAP] = cont_mode_i & ~clr_i & ((state_q == ST_FILL) | (state_q == ST_RUN))
                            & wr_seeded & ~wr_valid_i;
      err_now[ERR_UNF]    = rd_beat & ~wr_beat & (occ_q == '0);
      err_now[ERR_OVF]    = wr_beat & ~rd_beat & (occ_q == DEPTH_C);
   end
   assign any_err = |err_now;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE, ST_HALT: if (start_i) state_d = ST_ARMED;
         ST_ARMED:         if (wr_beat) state_d = rd_beat ? ST_RUN : ST_FILL;
         ST_FILL:          if (rd_beat) state_d = ST_RUN;
         ST_RUN:           ;
         default:          state_d = ST_IDLE;
      endcase
      if ((STOP_ON_ERR != 0) && any_err) state_d = ST_HALT;
   end

   always_comb begin
      error_d   = error_q;
      err_cnt_d = err_cnt_q;
      fe_vld_d  = fe_vld_q;
      fe_exp_d  = fe_exp_q;
      fe_act_d  = fe_act_q;
      wrap_d    = wrap_q;
      fill_d    = fill_q;
      occ_d     = occ_q;
      fw_vld_d  = fw_vld_q;
      fw_cnt_d  = fw_cnt_q;
      if (stat_clr) begin
         error_d   = '0;
         err_cnt_d = '0;
         fe_vld_d  = 1'b0;
         fe_exp_d  = '0;
         fe_act_d  = '0;
         wrap_d    = '0;
         fill_d    = '0;
         occ_d     = '0;
         fw_vld_d  = 1'b0;
         fw_cnt_d  = '0;
      end else begin
         error_d = error_q | err_now;
         if (any_err && (err_cnt_q != SAT32)) err_cnt_d = err_cnt_q + 32'd1;
         if (any_err && !fe_vld_q) begin
            fe_vld_d = 1'b1;
            if (|(err_now & RD_SIDE_MASK)) begin
               fe_exp_d = rd_exp;
               fe_act_d = rd_data_i;
            end else begin
               fe_exp_d = wr_exp;
               fe_act_d = wr_data_i;
            end
         end
         if (rd_wrap && (wrap_q != SAT32)) wrap_d = wrap_q + 32'd1;
         if ((state_q == ST_FILL) && (fill_q != SAT32)) fill_d = fill_q + 32'd1;
         if (wr_beat && !rd_beat && (occ_q != DEPTH_C))
            occ_d = occ_q + OCC_W'(1);
         else if (rd_beat && !wr_beat && (occ_q != '0))
            occ_d = occ_q - OCC_W'(1);
         if (wr_beat && !fw_vld_q) begin
            fw_vld_d = 1'b1;
            fw_cnt_d = wr_data_i[CNT_W-1:0];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= ST_IDLE;
         error_q   <= '0;
         err_cnt_q <= '0;
         fe_vld_q  <= 1'b0;
         fe_exp_q  <= '0;
         fe_act_q  <= '0;
         wrap_q    <= '0;
         fill_q    <= '0;
         occ_q     <= '0;
         fw_vld_q  <= 1'b0;
         fw_cnt_q  <= '0;
      end else begin
         state_q   <= state_d;
         error_q   <= error_d;
         err_cnt_q <= err_cnt_d;
         fe_vld_q  <= fe_vld_d;
         fe_exp_q  <= fe_exp_d;
         fe_act_q  <= fe_act_d;
         wrap_q    <= wrap_d;
         fill_q    <= fill_d;
         occ_q     <= occ_d;
         fw_vld_q  <= fw_vld_d;
         fw_cnt_q  <= fw_cnt_d;
      end
   end

   assign state_o         = state_q;
   assign error_o         = error_q;
   assign err_count_o     = err_cnt_q;
   assign first_err_vld_o = fe_vld_q;
   assign first_err_exp_o = fe_exp_q;
   assign first_err_act_o = fe_act_q;
   assign wrap_count_o    = wrap_q;
   assign fill_latency_o  = fill_q;
   assign occupancy_o     = occ_q;

endmodule

// File: tb/tb_ddr_fifo_stream_checker.sv
// Directed bench: two checkers on shared stimulus, one free-running and one
// that halts on the first error.
module tb_ddr_fifo_stream_checker;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0, clr = 1'b0, cont_mode = 1'b0;
   logic [47:0] wr_data = '0, rd_data = '0;
   logic        wr_valid = 1'b0, rd_valid = 1'b0;

   logic [2:0]  state, h_state;
   logic [7:0]  error, h_error;
   logic [31:0] err_count, h_err_count, wrap_count, h_wrap_count, fill_latency, h_fill_latency;
   logic        fe_vld, h_fe_vld;
   logic [47:0] fe_exp, h_fe_exp, fe_act, h_fe_act;
   logic [15:0] occupancy, h_occupancy;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   ddr_fifo_stream_checker dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .clr_i(clr), .cont_mode_i(cont_mode),
      .wr_data_i(wr_data), .wr_valid_i(wr_valid), .rd_data_i(rd_data), .rd_valid_i(rd_valid),
      .state_o(state), .error_o(error), .err_count_o(err_count), .first_err_vld_o(fe_vld),
      .first_err_exp_o(fe_exp), .first_err_act_o(fe_act), .wrap_count_o(wrap_count),
      .fill_latency_o(fill_latency), .occupancy_o(occupancy)
   );

   ddr_fifo_stream_checker #(.STOP_ON_ERR(1)) dut_h (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .clr_i(clr), .cont_mode_i(cont_mode),
      .wr_data_i(wr_data), .wr_valid_i(wr_valid), .rd_data_i(rd_data), .rd_valid_i(rd_valid),
      .state_o(h_state), .error_o(h_error), .err_count_o(h_err_count), .first_err_vld_o(h_fe_vld),
      .first_err_exp_o(h_fe_exp), .first_err_act_o(h_fe_act), .wrap_count_o(h_wrap_count),
      .fill_latency_o(h_fill_latency), .occupancy_o(h_occupancy)
   );

   function automatic logic [47:0] pat(input logic [31:0] c);
      return {c[15:0], c};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: drive beats, let the edge sample them, then look at the result.
   task automatic step(input logic wv, input logic [47:0] wd, input logic rv, input logic [47:0] rd);
      wr_valid = wv; wr_data = wd; rd_valid = rv; rd_data = rd;
      @(posedge clk); #1;
      start = 1'b0; clr = 1'b0; wr_valid = 1'b0; rd_valid = 1'b0;
   endtask

   task automatic restart();
      rst_n = 1'b0; cont_mode = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      start = 1'b1;
      step(1'b0, '0, 1'b0, '0);
   endtask

   initial begin
      #12;
      chk("rst_state", state, 0);
      chk("rst_error", error, 0);
      chk("rst_occ", occupancy, 0);
      chk("rst_errcnt", err_count, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Write 0..99, reads trail by 10 cycles.
      start = 1'b1;
      step(1'b0, '0, 1'b0, '0);
      chk("armed", state, 1);
      for (int i = 0; i < 100; i++) begin
         step(1'b1, pat(i), (i >= 10), pat((i >= 10) ? i - 10 : 0));
         if (i == 0) chk("fill_state", state, 2);
      end
      chk("p1_state", state, 3);
      chk("p1_fill", fill_latency, 10);
      chk("p1_occ", occupancy, 10);
      chk("p1_error", error, 0);
      chk("p1_h_state", h_state, 3);
      start = 1'b1;
      step(1'b0, '0, 1'b0, '0);
      chk("start_in_run_state", state, 3);
      chk("start_in_run_occ", occupancy, 10);
      chk("start_in_run_fill", fill_latency, 10);

      // Read stream skips 0x37.
      restart();
      for (int i = 0; i < 16; i++) begin
         int j;
         j = i - 2;
         step(1'b1, pat(32'h30 + i), (i >= 2), pat(32'h30 + j + ((j >= 7) ? 1 : 0)));
         if (i == 9) chk("skip_h_halt", h_state, 4);
      end
      chk("skip_error", error, 8'h01);
      chk("skip_errcnt", err_count, 1);
      chk("skip_fe_vld", fe_vld, 1);
      chk("skip_fe_exp", fe_exp[31:0], 32'h37);
      chk("skip_fe_act", fe_act[31:0], 32'h38);
      chk("skip_occ", occupancy, 2);
      chk("skip_h_errcnt", h_err_count, 1);

      // Counter wrap through all-ones on both streams.
      restart();
      begin
         logic [31:0] w [5];
         w[0] = 32'hFFFF_FFFD; w[1] = 32'hFFFF_FFFE; w[2] = 32'hFFFF_FFFF; w[3] = 32'h0; w[4] = 32'h1;
         for (int i = 0; i < 6; i++)
            step((i < 5), pat(w[(i < 5) ? i : 0]), (i >= 1), pat(w[(i >= 1) ? i - 1 : 0]));
      end
      chk("wrap_error", error, 0);
      chk("wrap_count", wrap_count, 1);
      chk("wrap_fill", fill_latency, 1);
      chk("wrap_occ", occupancy, 0);

      // Corrupt tag on the write side.
      restart();
      step(1'b1, pat(32'h5676), 1'b0, '0);
      step(1'b1, pat(32'h5677), 1'b0, '0);
      step(1'b1, 48'h1234_0000_5678, 1'b0, '0);
      chk("tag_error", error, 8'h04);
      chk("tag_fe_act", fe_act, 48'h1234_0000_5678);
      chk("tag_fe_exp", fe_exp, 48'h5678_0000_5678);
      chk("tag_h_state", h_state, 4);
      step(1'b1, pat(32'h5679), 1'b0, '0);
      chk("tag_occ", occupancy, 4);
      chk("tag_state", state, 2);
      chk("tag_h_occ_frozen", h_occupancy, 3);
      chk("tag_h_errcnt", h_err_count, 1);

      // Continuous-mode read gap, then underflow.
      restart();
      cont_mode = 1'b1;
      step(1'b1, pat(0), 1'b1, pat(0));
      chk("same_cycle_state", state, 3);
      chk("same_cycle_fill", fill_latency, 0);
      step(1'b1, pat(1), 1'b1, pat(1));
      step(1'b1, pat(2), 1'b0, '0);
      chk("gap_error", error, 8'h10);
      chk("gap_h_state", h_state, 4);
      step(1'b1, pat(3), 1'b1, pat(2));
      cont_mode = 1'b0;
      step(1'b0, '0, 1'b1, pat(3));
      step(1'b0, '0, 1'b1, pat(4));
      chk("unf_error", error, 8'h50);
      chk("unf_occ", occupancy, 0);
      chk("unf_errcnt", err_count, 2);

      // clr in RUN with a colliding beat, then a reseeded stream.
      clr = 1'b1;
      step(1'b0, '0, 1'b1, pat(5));
      chk("clr_state", state, 3);
      chk("clr_error", error, 0);
      chk("clr_errcnt", err_count, 0);
      chk("clr_fe_vld", fe_vld, 0);
      chk("clr_occ", occupancy, 0);
      step(1'b1, pat(700), 1'b1, pat(700));
      chk("reseed_error", error, 0);
      step(1'b1, pat(701), 1'b0, '0);
      chk("reseed_occ", occupancy, 1);
      step(1'b1, pat(703), 1'b0, '0);
      chk("wrseq_error", error, 8'h02);
      chk("wrseq_occ", occupancy, 2);

      // Asynchronous reset between clock edges.
      #1 rst_n = 1'b0;
      #1;
      chk("arst_state", state, 0);
      chk("arst_error", error, 0);
      chk("arst_occ", occupancy, 0);
      chk("arst_errcnt", err_count, 0);
      chk("arst_fe_vld", fe_vld, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
